fb_fetch: RTL and testbench
===========================

FB_FETCH -- requirements
Module: fb_fetch

Interface
REQ-001 Parameter BASE_ADDR, 24'h000000: DRAM word address of the first framebuffer word.
REQ-002 Parameter FRAME_WORDS, 19200: number of 32-bit words fetched per frame.
REQ-003 Parameter FIFO_AW, 3: log2 of the word-FIFO depth (depth 8).
REQ-004 clk  in  1: single clock, 50 MHz CLOCK_50 domain; clock and reset fixed as one clock, asynchronous active-low reset rst_n.
REQ-005 rst_n  in  1: asynchronous active-low reset.
REQ-006 frame_sync  in  1: vertical sync from the video generator, synchronous to clk; its rising edge starts a new frame.
REQ-007 addr1  out  24: read address to bus_arbiter port 1.
REQ-008 req_read1  out  1: read request to bus_arbiter port 1.
REQ-009 data1  in  32: read data from bus_arbiter port 1.
REQ-010 data_valid1  in  1: one-cycle pulse qualifying data1.
REQ-011 pix_data  out  4: current pixel, one nibble.
REQ-012 pix_valid  out  1: pix_data is valid.
REQ-013 pix_ready  in  1: consumer takes the pixel this cycle when pix_valid is high.
REQ-014 underrun  out  1: sticky flag; pix_ready was high while pix_valid was low during an active frame.

Function
REQ-015 Fetch FSM states: IDLE, REQ, DRAIN. In IDLE with frame active, word count < FRAME_WORDS and FIFO free entries >= 1, the FSM enters REQ.
REQ-016 In REQ: req_read1=1 and addr1 is held stable until the cycle data_valid1=1. That cycle, data1 is written to the FIFO, the address increments by 1 and the word count increments. req_read1 drops the following cycle and the FSM returns to IDLE.
REQ-017 At most one read is outstanding; the read-to-next-request gap is at least one idle cycle.
REQ-018 addr1 = BASE_ADDR + word count, using 24-bit wrap-around arithmetic.
REQ-019 After FRAME_WORDS words, no further requests are made until the next frame_sync rising edge.
REQ-020 On a frame_sync rising edge: flush the FIFO, clear the pixel unpacker, reset the word count to 0, mark the frame active. Taking effect on the next cycle.
REQ-021 If frame_sync rises while in REQ, the FSM enters DRAIN. It holds req_read1 until data_valid1, discards that word, then returns to IDLE. The first request of the new frame uses BASE_ADDR.
REQ-022 If frame_sync rises in the same cycle as data_valid1 in REQ, the word is discarded and the FSM goes directly to IDLE.
REQ-023 Unpacker: loads one FIFO word when it is empty or its last nibble is consumed. It emits nibbles LSB-first, [3:0] first and [31:28] last, one per pix_ready handshake.
REQ-024 A FIFO word can move into the unpacker in the same cycle as the previous last nibble is accepted, giving zero bubble at steady state.
REQ-025 pix_valid is high whenever the unpacker holds unconsumed nibbles. pix_data is stable while pix_valid=1 and pix_ready=0.
REQ-026 FIFO full: no write occurs, because of REQ-015 gating. FIFO empty: the unpacker stalls and pix_valid goes low.
REQ-027 Simultaneous FIFO write and read when full or empty is permitted and leaves the occupancy unchanged.
REQ-028 underrun is set per REQ-014, is cleared only by reset, and is ignored before the first frame_sync.

Reset
REQ-029 rst_n low asynchronously forces these values: FSM=IDLE, req_read1=0, addr1=BASE_ADDR, pix_valid=0, pix_data=0, underrun=0, FIFO empty, word count 0, frame inactive.
REQ-030 The frame_sync edge detector resets to 1, so a high frame_sync at reset release is not treated as an edge.
REQ-031 Reset asserted mid-request drops req_read1 immediately. A data_valid1 arriving after release while in IDLE is ignored.

Structure
REQ-032 The shared package holds the FSM state enum, the DRAM address width (24), the bus data width (32) and the pixel width (4).
REQ-033 The word FIFO is a separate sub-module, fb_word_fifo, parameterised by width and FIFO_AW, with full, empty and count outputs.
REQ-034 Only one always block drives the request FSM. The unpacker stays in fb_fetch.

Verification
REQ-035 Reset, then frame_sync pulse, arbiter answers every request after 3 cycles -> first addr1=0x000000, then 0x000001; pix_data stream is 0,1,...,7 for data1=0x76543210.
REQ-036 pix_ready held 0 -> exactly 8 requests issued, then req_read1 stays 0. One pix_ready pulse consumes one nibble; no new request until a full word is consumed.
REQ-037 FRAME_WORDS=4 -> exactly 4 requests (addr 0..3), then none. The next frame_sync restarts at addr 0.
REQ-038 frame_sync rises while req_read1=1 with addr 0x000005 -> returned word discarded, no pixel from it, next request addr 0x000000.
REQ-039 pix_ready=1 constantly after the first frame_sync, arbiter latency 20 cycles -> underrun=1 and stays 1 until rst_n low.
REQ-040 rst_n pulsed low during REQ -> req_read1=0 the same cycle; after release, a late data_valid1 is ignored and pix_valid stays 0.

Source files
------------

// File: rtl/fb_fetch_pkg.sv
// Shared widths and request-FSM state encoding for the framebuffer fetch block.
`timescale 1ns/1ps
package fb_fetch_pkg;

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PIX_W     = 4;
  localparam int unsigned NIBBLES   = DATA_W / PIX_W;
  localparam int unsigned NIB_IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous word FIFO with show-ahead read data, flush, and registered status.
`timescale 1ns/1ps
module fb_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             bypass;
  logic             do_wr;
  logic             do_rd;
  logic [AW:0]      count_nxt;

  // Write/read qualification; an empty FIFO written and read together passes the word straight through.
  always_comb begin
    bypass    = empty && wr_en && rd_en;
    do_wr     = wr_en && (!full || rd_en) && !bypass;
    do_rd     = rd_en && !empty;
    count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    rd_data_c = empty ? wr_data : mem[rd_ptr];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/fb_fetch.sv
// Framebuffer fetch: reads frame words from DRAM via the arbiter, buffers them, and streams nibbles.
`timescale 1ns/1ps
module fb_fetch
  import fb_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 24'h000000,
  parameter int unsigned       FRAME_WORDS = 19200,
  parameter int unsigned       FIFO_AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_sync,
  output logic [ADDR_W-1:0] addr1,
  output logic              req_read1,
  input  logic [DATA_W-1:0] data1,
  input  logic              data_valid1,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              underrun
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam int unsigned HELD_W = FIFO_AW + 2;

  fetch_state_e          state;
  fetch_state_e          state_nxt;
  logic                  fs_d;
  logic                  fs_rise;
  logic                  frame_active;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      word_cnt_nxt;
  logic                  accept;
  logic                  room;
  logic [HELD_W-1:0]     held;

  logic [DATA_W-1:0]     fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_AW:0]      fifo_count;

  logic [DATA_W-1:0]     sreg;
  logic [NIB_IDX_W-1:0]  nib_idx;
  logic                  take;
  logic                  last;
  logic                  load;

  assign fs_rise = frame_sync && !fs_d;

  // The word parked in the unpacker counts against the buffer so at most DEPTH words are held.
  assign held = HELD_W'(fifo_count) + HELD_W'(pix_valid);
  assign room = !fifo_full && (held < HELD_W'(DEPTH));

  // Request FSM next-state and word acceptance.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_active && !fs_rise && (word_cnt < CNT_W'(FRAME_WORDS)) && room)
          state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (data_valid1) begin
          state_nxt = ST_IDLE;
          accept    = !fs_rise;
        end else if (fs_rise) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (data_valid1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (fs_rise)     word_cnt_nxt = '0;
    else if (accept) word_cnt_nxt = word_cnt + CNT_W'(1);
    else             word_cnt_nxt = word_cnt;
  end

  // Request FSM registers; the address only moves while no read is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_read1 <= 1'b0;
      addr1     <= BASE_ADDR;
    end else begin
      state     <= state_nxt;
      req_read1 <= (state_nxt != ST_IDLE);
      if (state_nxt == ST_IDLE)
        addr1 <= BASE_ADDR + ADDR_W'(word_cnt_nxt);
    end
  end

  // Frame tracking: sync edge detector, word count and frame-active flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_d         <= 1'b1;
      word_cnt     <= '0;
      frame_active <= 1'b0;
    end else begin
      fs_d     <= frame_sync;
      word_cnt <= word_cnt_nxt;
      if (fs_rise) frame_active <= 1'b1;
    end
  end

  fb_word_fifo #(
    .WIDTH (DATA_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fs_rise),
    .wr_en     (accept),
    .wr_data   (data1),
    .rd_en     (load),
    .rd_data_c (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Unpacker handshake: reload when empty or when the last nibble leaves this cycle.
  always_comb begin
    take = pix_valid && pix_ready;
    last = take && (nib_idx == NIB_IDX_W'(NIBBLES - 1));
    load = (!pix_valid || last) && !fifo_empty && !fs_rise;
  end

  // Unpacker shift register, LSB nibble first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      nib_idx   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else if (fs_rise) begin
      sreg      <= '0;
      nib_idx   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else if (load) begin
      sreg      <= fifo_rd_data;
      nib_idx   <= '0;
      pix_valid <= 1'b1;
      pix_data  <= fifo_rd_data[PIX_W-1:0];
    end else if (take) begin
      sreg     <= sreg >> PIX_W;
      nib_idx  <= nib_idx + NIB_IDX_W'(1);
      pix_data <= sreg[2*PIX_W-1:PIX_W];
      if (last) pix_valid <= 1'b0;
    end
  end

  // Sticky underrun, armed only once a frame has started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      underrun <= 1'b0;
    else if (frame_active && pix_ready && !pix_valid) underrun <= 1'b1;
  end

endmodule

// File: tb/tb_fb_fetch.sv
// Directed bench for fb_fetch with a latency-programmable arbiter model.
`timescale 1ns/1ps
module tb_fb_fetch;
  import fb_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_sync = 1'b0;
  logic [23:0] addr1;
  logic        req_read1;
  logic [31:0] data1;
  logic        data_valid1;
  logic [3:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        underrun;

  logic [23:0] addr1_b;
  logic        req_read1_b;
  logic [31:0] data1_b;
  logic        data_valid1_b;
  logic [3:0]  pix_data_b;
  logic        pix_valid_b;
  logic        pix_ready_b = 1'b0;
  logic        underrun_b;

  int          n_checks = 0;
  int          n_pass = 0;
  int          lat = 3;
  bit          arb_en = 1'b1;
  int          inject_req = 0;
  logic [23:0] log_a[$];
  logic [23:0] log_b[$];

  always #10 clk = ~clk;

  fb_fetch u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_sync  (frame_sync),
    .addr1       (addr1),
    .req_read1   (req_read1),
    .data1       (data1),
    .data_valid1 (data_valid1),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .underrun    (underrun)
  );

  fb_fetch #(.FRAME_WORDS(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_sync  (frame_sync),
    .addr1       (addr1_b),
    .req_read1   (req_read1_b),
    .data1       (data1_b),
    .data_valid1 (data_valid1_b),
    .pix_data    (pix_data_b),
    .pix_valid   (pix_valid_b),
    .pix_ready   (pix_ready_b),
    .underrun    (underrun_b)
  );

  function automatic logic [31:0] word_for(input logic [23:0] a);
    return 32'h76543210 ^ {8{a[3:0]}};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Arbiter model for the main instance, plus one-shot late data_valid1 injection.
  initial begin
    logic [23:0] a;
    int inject_done;
    inject_done = 0;
    data1 = '0;
    data_valid1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) log_a.delete();
      if (inject_req != inject_done) begin
        inject_done++;
        data1 = 32'hFEDCBA98;
        data_valid1 = 1'b1;
        @(negedge clk);
        data_valid1 = 1'b0;
      end else if (arb_en && req_read1) begin
        a = addr1;
        log_a.push_back(a);
        repeat (lat) @(negedge clk);
        data1 = word_for(a);
        data_valid1 = 1'b1;
        @(negedge clk);
        data_valid1 = 1'b0;
      end
    end
  end

  // Arbiter model for the FRAME_WORDS=4 instance, fixed latency 3.
  initial begin
    logic [23:0] a;
    data1_b = '0;
    data_valid1_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) log_b.delete();
      if (req_read1_b) begin
        a = addr1_b;
        log_b.push_back(a);
        repeat (3) @(negedge clk);
        data1_b = word_for(a);
        data_valid1_b = 1'b1;
        @(negedge clk);
        data_valid1_b = 1'b0;
      end
    end
  end

  task automatic do_reset(input logic fs_level);
    rst_n = 1'b0;
    frame_sync = fs_level;
    pix_ready = 1'b0;
    lat = 3;
    arb_en = 1'b1;
    repeat (25) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!pix_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(pix_valid), 32'd1);
  endtask

  task automatic take_one(input string tag);
    wait_valid(tag);
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
  endtask

  initial begin
    int n;

    // Reset values, with frame_sync high across release (must not count as an edge).
    do_reset(1'b1);
    check("rst_req",       32'(req_read1), 32'd0);
    check("rst_addr",      32'(addr1),     32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data",  32'(pix_data),  32'd0);
    check("rst_underrun",  32'(underrun),  32'd0);
    repeat (10) @(negedge clk);
    check("fs_high_release_no_req", 32'(log_a.size()), 32'd0);

    // First frame: addresses 0,1 and nibble order of word 0x76543210.
    do_reset(1'b0);
    pulse_fs();
    n = 0;
    while (log_a.size() < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t2_two_reqs", 32'(log_a.size() >= 2), 32'd1);
    check("t2_addr0", 32'(log_a[0]), 32'd0);
    check("t2_addr1", 32'(log_a[1]), 32'd1);
    wait_valid("t2_first_valid");
    pix_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid($sformatf("t2_valid%0d", i));
      check($sformatf("t2_pix%0d", i), 32'(pix_data), 32'(i));
      @(negedge clk);
    end
    pix_ready = 1'b0;
    check("t2_no_underrun", 32'(underrun), 32'd0);

    // Stalled consumer: buffer budget of 8 words, FRAME_WORDS=4 instance stops at 4.
    do_reset(1'b0);
    pulse_fs();
    repeat (200) @(negedge clk);
    check("t3_req_count",  32'(log_a.size()), 32'd8);
    check("t3_req_idle",   32'(req_read1),    32'd0);
    check("t3_b_count",    32'(log_b.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_b_addr%0d", i), 32'(log_b[i]), 32'(i));
    check("t3_b_idle",      32'(req_read1_b), 32'd0);
    check("t3_b_valid",     32'(pix_valid_b), 32'd1);
    check("t3_b_pix",       32'(pix_data_b),  32'd0);
    check("t3_b_underrun",  32'(underrun_b),  32'd0);
    take_one("t3_take0");
    repeat (30) @(negedge clk);
    check("t3_one_nibble_no_req", 32'(log_a.size()), 32'd8);
    check("t3_second_nibble",     32'(pix_data),     32'd1);
    for (int i = 1; i < 8; i++) take_one($sformatf("t3_take%0d", i));
    repeat (30) @(negedge clk);
    check("t3_refill_count", 32'(log_a.size()), 32'd9);
    check("t3_refill_addr",  32'(log_a[8]),     32'd8);
    check("t3_next_word_pix", 32'(pix_data),    32'd1);
    pulse_fs();
    repeat (50) @(negedge clk);
    check("t3_b_restart_count", 32'(log_b.size()), 32'd8);
    check("t3_b_restart_addr",  32'(log_b[4]),     32'd0);
    check("t3_b_restart_last",  32'(log_b[7]),     32'd3);

    // frame_sync during an outstanding read of address 5.
    do_reset(1'b0);
    pulse_fs();
    n = 0;
    while (!(req_read1 && addr1 == 24'd5) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t4_hit_addr5", 32'(req_read1 && addr1 == 24'd5), 32'd1);
    pulse_fs();
    check("t4_drain_req",  32'(req_read1), 32'd1);
    check("t4_drain_addr", 32'(addr1),     32'd5);
    n = 0;
    while (log_a.size() < 7 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t4_req_count", 32'(log_a.size() >= 7), 32'd1);
    check("t4_old_addr",  32'(log_a[5]), 32'd5);
    check("t4_new_addr",  32'(log_a[6]), 32'd0);
    wait_valid("t4_valid");
    check("t4_first_pix", 32'(pix_data), 32'd0);
    take_one("t4_take");
    wait_valid("t4_valid2");
    check("t4_second_pix", 32'(pix_data), 32'd1);

    // Underrun: ignored before a frame, then sticky until reset.
    do_reset(1'b0);
    pix_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_pre_frame", 32'(underrun), 32'd0);
    lat = 20;
    pulse_fs();
    repeat (60) @(negedge clk);
    check("t5_set", 32'(underrun), 32'd1);
    pix_ready = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_sticky", 32'(underrun), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_reset_clear", 32'(underrun), 32'd0);
    @(negedge clk);

    // Reset mid-request drops the request at once; a late data_valid1 is ignored.
    do_reset(1'b0);
    arb_en = 1'b0;
    pulse_fs();
    n = 0;
    while (!req_read1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_req_up", 32'(req_read1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", 32'(req_read1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    inject_req++;
    repeat (10) @(negedge clk);
    check("t6_no_pix", 32'(pix_valid), 32'd0);
    check("t6_no_req", 32'(req_read1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
